// File: rtl/controlador_led_pwm.sv
// rtl/controlador_led_pwm.sv - memory-mapped LED controller with global PWM brightness and per-LED blink gating.
// The blink mask, period register and blink FSM exist only when CONTROLADOR_LED_BLINK_EN is defined.
module controlador_led_pwm #(
  parameter int N_LEDS = 8,
  parameter int DATA_W = 16,
  parameter int PWM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic              we,
  input  logic [1:0]        addr,
  output logic [DATA_W-1:0] rdata,
  output logic [N_LEDS-1:0] Led
);

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_PERIOD = 2'd3;

  logic [N_LEDS-1:0] value_q;
  logic [PWM_W-1:0]  duty_q;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              pwm_on;
  logic [N_LEDS-1:0] blink_gate;
  logic              unused_in;

  // Keeps bus bits that no register stores from being flagged as dead.
  assign unused_in = ^in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
      duty_q  <= '1;
    end else begin
      if (we && addr == ADDR_VALUE) value_q <= in[N_LEDS-1:0];
      if (we && addr == ADDR_DUTY)  duty_q  <= in[PWM_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  // Full-scale duty bypasses the compare so the LED never drops out at the wrap.
  assign pwm_on = (duty_q == '1) || (pwm_cnt < duty_q);

`ifdef CONTROLADOR_LED_BLINK_EN
  typedef enum logic {BLK_OFF = 1'b0, BLK_ON = 1'b1} blk_state_t;

  blk_state_t        state, state_next;
  logic [N_LEDS-1:0] mask_q;
  logic [DATA_W-1:0] period_q;
  logic [DATA_W-1:0] blk_cnt, blk_cnt_next;
  logic              period_wr;
  logic              phase;

  assign period_wr = we && (addr == ADDR_PERIOD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q   <= '0;
      period_q <= '1;
    end else begin
      if (we && addr == ADDR_MASK) mask_q <= in[N_LEDS-1:0];
      if (period_wr)               period_q <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= BLK_ON;
      blk_cnt <= '0;
    end else begin
      state   <= state_next;
      blk_cnt <= blk_cnt_next;
    end
  end

  // A period write restarts the blink in the ON phase, overriding the terminal toggle.
  always_comb begin
    state_next   = state;
    blk_cnt_next = blk_cnt + DATA_W'(1);
    if (period_wr) begin
      state_next   = BLK_ON;
      blk_cnt_next = '0;
    end else if (blk_cnt == period_q) begin
      state_next   = (state == BLK_ON) ? BLK_OFF : BLK_ON;
      blk_cnt_next = '0;
    end
  end

  always_comb begin
    phase      = (state == BLK_ON);
    blink_gate = ~mask_q | {N_LEDS{phase}};
  end
`else
  assign blink_gate = '1;
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_VALUE:  rdata[N_LEDS-1:0] = value_q;
      ADDR_DUTY:   rdata[PWM_W-1:0]  = duty_q;
`ifdef CONTROLADOR_LED_BLINK_EN
      ADDR_MASK:   rdata[N_LEDS-1:0] = mask_q;
      ADDR_PERIOD: rdata             = period_q;
`endif
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) Led <= '0;
    else        Led <= value_q & {N_LEDS{pwm_on}} & blink_gate;
  end

endmodule

// File: tb/tb_controlador_led_pwm.sv
// tb/tb_controlador_led_pwm.sv - scoreboard bench for controlador_led_pwm.
// Blink checks are compiled in when CONTROLADOR_LED_BLINK_EN is defined; otherwise the no-blink checks run.
module tb_controlador_led_pwm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wdata;
  logic        we;
  logic [1:0]  addr;
  logic [15:0] rdata;
  logic [7:0]  Led;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  controlador_led_pwm #(.N_LEDS(8), .DATA_W(16), .PWM_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (wdata),
    .we    (we),
    .addr  (addr),
    .rdata (rdata),
    .Led   (Led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] observed);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, observed, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] expv);
    addr = a;
    #1;
    sb_push(tag, {16'h0, expv});
    sb_pop_check({16'h0, rdata});
  endtask

  task automatic pwm_window(input string tag, input int highs);
    int cnt[8];
    for (int b = 0; b < 8; b++) cnt[b] = 0;
    for (int b = 0; b < 8; b++) sb_push(tag, 32'(highs));
    for (int c = 0; c < 256; c++) begin
      tick();
      for (int b = 0; b < 8; b++) cnt[b] += int'(Led[b]);
    end
    for (int b = 0; b < 8; b++) sb_pop_check(32'(cnt[b]));
  endtask

  function automatic logic [31:0] blink_exp(input int j, input int p);
    return ((((j - 1) / (p + 1)) % 2) == 0) ? 32'h0F : 32'h0C;
  endfunction

  task automatic blink_run(input string tag, input int p, input int n);
    for (int j = 1; j <= n; j++) begin
      tick();
      sb_push(tag, blink_exp(j, p));
      sb_pop_check({24'h0, Led});
    end
  endtask

`ifdef CONTROLADOR_LED_BLINK_EN
  localparam logic [15:0] PERIOD_RST = 16'hFFFF;
`else
  localparam logic [15:0] PERIOD_RST = 16'h0000;
`endif

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = 16'h0;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;

    sb_push("rst_led", 32'h0);
    sb_pop_check({24'h0, Led});
    rd_chk("rst_value", 2'd0, 16'h0000);
    rd_chk("rst_mask", 2'd1, 16'h0000);
    rd_chk("rst_duty", 2'd2, 16'h00FF);
    rd_chk("rst_period", 2'd3, PERIOD_RST);

    // Output latency: the write edge itself still drives the old value.
    wr(2'd0, 16'h00A5);
    sb_push("a5_latency", 32'h0);
    sb_pop_check({24'h0, Led});
    rd_chk("a5_rdata", 2'd0, 16'h00A5);
    for (int c = 0; c < 6; c++) begin
      tick();
      sb_push("a5_hold", 32'hA5);
      sb_pop_check({24'h0, Led});
    end

    wr(2'd0, 16'h00FF);
    wr(2'd2, 16'h0040);
    rd_chk("duty_rdata", 2'd2, 16'h0040);
    pwm_window("pwm_40", 64);
    wr(2'd2, 16'h0001);
    pwm_window("pwm_01", 1);
    wr(2'd2, 16'h0000);
    pwm_window("pwm_00", 0);
    wr(2'd2, 16'h00FF);
    pwm_window("pwm_ff", 256);

`ifdef CONTROLADOR_LED_BLINK_EN
    wr(2'd0, 16'h000F);
    wr(2'd1, 16'h0003);
    wr(2'd3, 16'h0004);
    blink_run("blink_p4", 4, 20);
    rd_chk("mask_rdata", 2'd1, 16'h0003);
    rd_chk("period_rdata", 2'd3, 16'h0004);

    wr(2'd3, 16'h0000);
    blink_run("blink_p0", 0, 8);

    wr(2'd3, 16'h0004);
    repeat (7) tick();
    wr(2'd3, 16'h0004);
    blink_run("reload_off", 4, 10);

    wr(2'd3, 16'h0004);
    repeat (4) tick();
    wr(2'd3, 16'h0004);
    blink_run("reload_tc", 4, 10);

    wr(2'd3, 16'h0002);
    repeat (4) tick();
`else
    wr(2'd0, 16'h00A5);
    wr(2'd1, 16'h00FF);
    wr(2'd3, 16'h1234);
    rd_chk("nb_mask_rdata", 2'd1, 16'h0000);
    rd_chk("nb_period_rdata", 2'd3, 16'h0000);
    for (int c = 0; c < 4; c++) begin
      tick();
      sb_push("nb_led", 32'hA5);
      sb_pop_check({24'h0, Led});
    end
`endif

    // Reset asserted together with a write: reset must win.
    rst_n = 1'b0;
    we    = 1'b1;
    addr  = 2'd0;
    wdata = 16'h00FF;
    tick();
    rst_n = 1'b1;
    we    = 1'b0;
    sb_push("rstwe_led0", 32'h0);
    sb_pop_check({24'h0, Led});
    rd_chk("rstwe_value", 2'd0, 16'h0000);
    rd_chk("rstwe_mask", 2'd1, 16'h0000);
    rd_chk("rstwe_duty", 2'd2, 16'h00FF);
    rd_chk("rstwe_period", 2'd3, PERIOD_RST);
    tick();
    sb_push("rstwe_led1", 32'h0);
    sb_pop_check({24'h0, Led});

    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controlador_led_pwm.md
# controlador_led_pwm

Memory-mapped LED output controller for the I/O subsystem, the parametrised successor to the single-register LED port. The CPU writes 16-bit words through a small register file: LED value, blink mask, global PWM brightness and blink period. A free-running PWM counter and a blink prescaler drive the registered `Led` outputs. Reset defaults to full brightness with blinking off, so software written for the old port works unchanged.

## Interface
Parameters:
- `N_LEDS`, 8, number of LED outputs (1..`DATA_W`).
- `DATA_W`, 16, bus data width.
- `PWM_W`, 8, brightness/PWM counter width (1..`DATA_W`).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in`  in  `DATA_W`  write data.
- `we`  in  1  write enable, sampled on rising edge.
- `addr`  in  2  register select.
- `rdata`  out  `DATA_W`  combinational readback of the register at `addr`.
- `Led`  out  `N_LEDS`  registered LED drive.

## Operation
- Register map. Unused upper bits are ignored on write and read as 0.
  - 0 `VALUE[N_LEDS-1:0]`: LED on/off pattern.
  - 1 `BLINK_MASK[N_LEDS-1:0]`: 1 = the LED is gated by the blink phase.
  - 2 `DUTY[PWM_W-1:0]`: global brightness.
  - 3 `PERIOD[DATA_W-1:0]`: blink half-period minus 1, in `clk` cycles.
- Reset values (`rst_n`=0 at an edge):
  - VALUE=0, BLINK_MASK=0.
  - DUTY=all-ones, PERIOD=all-ones.
  - `pwm_cnt`=0, `blk_cnt`=0, `phase`=1.
  - `Led`=0.
- Reset wins over `we` in the same cycle. Reset mid-blink or mid-PWM restarts both counters.
- PWM:
  - `pwm_cnt` increments every cycle and wraps 2^PWM_W−1 → 0.
  - `pwm_on` = (DUTY == all-ones) ? 1 : (`pwm_cnt` < DUTY).
  - DUTY=0 → always off. DUTY=all-ones → always on (no 1-cycle dropout).
- Blink state machine, two states ON (`phase`=1) and OFF (`phase`=0):
  - `blk_cnt` increments each cycle.
  - When `blk_cnt` == PERIOD: `blk_cnt` ← 0 and `phase` toggles. PERIOD=0 therefore toggles every cycle.
  - A write to PERIOD forces `blk_cnt` ← 0 and `phase` ← 1 on the same edge. This takes priority over the terminal-count toggle.
- Output: next `Led[i]` = VALUE[i] & `pwm_on` & (~BLINK_MASK[i] | `phase`), computed from current register and counter values.
- Writes to DUTY and BLINK_MASK do not disturb the counters.

## Timing
- A write sampled at edge k updates its register at edge k.
- `Led` reflects the new register value at edge k+1 (one cycle of output latency, same as the previous port).
- `rdata` is combinational from `addr` and the registers. It shows the new value immediately after edge k.
- The PWM period is exactly 2^PWM_W cycles. Each blink half-period is exactly PERIOD+1 cycles.
- Back-to-back writes on consecutive cycles are all accepted. There is no busy or stall signal.

## Configuration
- `CONTROLADOR_LED_BLINK_EN` defined: blink mask, period register, `blk_cnt` and `phase` are built as described above.
- Not defined:
  - The blink logic is removed and `phase` is treated as constant 1.
  - Writes to addresses 1 and 3 are ignored, and both read as 0.
  - `Led` = VALUE & `pwm_on`.
  - PWM behaviour and all other timing are unchanged.

## Test plan
- Reset, then write addr0=0x00A5 → `Led`=0xA5 exactly one cycle after the write edge, held constant (DUTY=0xFF); `rdata` at addr0 = 0x00A5.
- VALUE=0xFF, DUTY=0x40 → over any 256-cycle window each `Led` bit is high for exactly 64 cycles; DUTY=0x00 → 0 cycles high; DUTY=0xFF → 256 cycles high.
- (BLINK_EN) VALUE=0x0F, MASK=0x03, PERIOD=4 → `Led[1:0]` alternate 5 cycles on / 5 off starting on, with `Led[3:2]` constantly 1; addr1 reads 0x0003.
- (BLINK_EN) With PERIOD=0 → masked bits toggle every cycle. Rewriting PERIOD while `phase`=0 → `phase`=1 and `blk_cnt`=0 on the write edge.
- Assert `rst_n`=0 together with `we`=1 mid-blink → all registers reach their reset values, the write is discarded, and `Led`=0 on the following edge.
- (no BLINK_EN) Write addr1=0xFF → readback 0 and `Led` unaffected.
